// File: rtl/color_mapper_pipe.sv
// color_mapper_pipe
//   Three-stage pixel compositor. It draws NUM_SPR rectangular sprite layers
//   over a circular ball over a background texel, and it records per frame
//   which sprites the ball overlapped.
//   Stage 1: registers the pixel-aligned inputs, the ball offsets dx/dy and the
//            per-sprite opacity (box hit, non-key texel, latched enable).
//   Stage 2: registers dist^2 (21 bits) and radius^2 (20 bits).
//   Stage 3: registers the composited colour, out_valid and the collision flags.
// Ports
//   Clk, Reset_n                 clock; asynchronous active-low reset
//   DrawX, DrawY, pix_valid      current pixel coordinate and its valid strobe
//   frame_start                  one-cycle pulse at the first pixel of a frame
//   SprX, SprY, SprS             packed per-sprite top-left corner and square size
//   spr_rgb                      packed per-sprite texel colour {R,G,B}
//   BallX, BallY, Ball_size      ball centre and radius
//   bg_rgb                       background texel {R,G,B}
//   layer_en                     layer enables; bit NUM_SPR is the ball
//   Red, Green, Blue, out_valid  composited pixel, latency 3
//   hit                          per-sprite ball-overlap flags of the previous frame
module color_mapper_pipe #(
  parameter int unsigned NUM_SPR = 2,
  parameter int unsigned CW = 4,
  parameter logic [3*CW-1:0] KEY = {{CW{1'b1}}, {CW{1'b0}}, {CW{1'b1}}},
  parameter logic [3*CW-1:0] BALL_RGB = 12'hF70
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    pix_valid,
  input  logic                    frame_start,
  input  logic [10*NUM_SPR-1:0]   SprX,
  input  logic [10*NUM_SPR-1:0]   SprY,
  input  logic [10*NUM_SPR-1:0]   SprS,
  input  logic [3*CW*NUM_SPR-1:0] spr_rgb,
  input  logic [9:0]              BallX,
  input  logic [9:0]              BallY,
  input  logic [9:0]              Ball_size,
  input  logic [3*CW-1:0]         bg_rgb,
  input  logic [NUM_SPR:0]        layer_en,
  output logic [CW-1:0]           Red,
  output logic [CW-1:0]           Green,
  output logic [CW-1:0]           Blue,
  output logic                    out_valid,
  output logic [NUM_SPR-1:0]      hit
);

  localparam int unsigned PW = 3 * CW;

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  logic [NUM_SPR:0]    r_layer_en_q;
  logic [NUM_SPR:0]    w_en;
  logic [NUM_SPR-1:0]  w_opq1;
  logic [10:0]         w_dx;
  logic [10:0]         w_dy;

  // A frame_start pixel already uses the enables sampled on that same cycle.
  assign w_en = frame_start ? layer_en : r_layer_en_q;

  // Two's complement 11-bit offsets; bit 10 is the sign.
  assign w_dx = {1'b0, DrawX} - {1'b0, BallX};
  assign w_dy = {1'b0, DrawY} - {1'b0, BallY};

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    logic [10:0] w_xend;
    logic [10:0] w_yend;
    logic        w_box;
    // Box end computed at 11 bits so a sprite near the right/bottom edge never wraps.
    assign w_xend = {1'b0, SprX[10*g +: 10]} + {1'b0, SprS[10*g +: 10]};
    assign w_yend = {1'b0, SprY[10*g +: 10]} + {1'b0, SprS[10*g +: 10]};
    assign w_box  = (DrawX >= SprX[10*g +: 10]) && ({1'b0, DrawX} < w_xend) &&
                    (DrawY >= SprY[10*g +: 10]) && ({1'b0, DrawY} < w_yend);
    assign w_opq1[g] = w_box && (spr_rgb[PW*g +: PW] != KEY) && w_en[g];
  end

  logic                    r1_valid;
  logic                    r1_fs;
  logic [PW-1:0]           r1_bg;
  logic [PW*NUM_SPR-1:0]   r1_spr;
  logic [NUM_SPR-1:0]      r1_opq;
  logic                    r1_ball_en;
  logic [10:0]             r1_dx;
  logic [10:0]             r1_dy;
  logic [9:0]              r1_size;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_layer_en_q <= '1;
      r1_valid     <= 1'b0;
      r1_fs        <= 1'b0;
      r1_bg        <= '0;
      r1_spr       <= '0;
      r1_opq       <= '0;
      r1_ball_en   <= 1'b0;
      r1_dx        <= '0;
      r1_dy        <= '0;
      r1_size      <= '0;
    end else begin
      if (frame_start)
        r_layer_en_q <= layer_en;
      r1_valid   <= pix_valid;
      r1_fs      <= frame_start;
      r1_bg      <= bg_rgb;
      r1_spr     <= spr_rgb;
      r1_opq     <= w_opq1;
      r1_ball_en <= w_en[NUM_SPR];
      r1_dx      <= w_dx;
      r1_dy      <= w_dy;
      r1_size    <= Ball_size;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2
  // ---------------------------------------------------------------------------
  logic [10:0] w_adx;
  logic [10:0] w_ady;
  logic [20:0] w_ax;
  logic [20:0] w_ay;
  logic [20:0] w_d2;
  logic [19:0] w_sz;
  logic [19:0] w_s2;

  // |dx|,|dy| <= 1023, so the sum of squares fits in 21 bits.
  assign w_adx = r1_dx[10] ? (11'd0 - r1_dx) : r1_dx;
  assign w_ady = r1_dy[10] ? (11'd0 - r1_dy) : r1_dy;
  assign w_ax  = {10'd0, w_adx};
  assign w_ay  = {10'd0, w_ady};
  assign w_d2  = (w_ax * w_ax) + (w_ay * w_ay);
  assign w_sz  = {10'd0, r1_size};
  assign w_s2  = w_sz * w_sz;

  logic                    r2_valid;
  logic                    r2_fs;
  logic [PW-1:0]           r2_bg;
  logic [PW*NUM_SPR-1:0]   r2_spr;
  logic [NUM_SPR-1:0]      r2_opq;
  logic                    r2_ball_en;
  logic [20:0]             r2_d2;
  logic [19:0]             r2_s2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r2_valid   <= 1'b0;
      r2_fs      <= 1'b0;
      r2_bg      <= '0;
      r2_spr     <= '0;
      r2_opq     <= '0;
      r2_ball_en <= 1'b0;
      r2_d2      <= '0;
      r2_s2      <= '0;
    end else begin
      r2_valid   <= r1_valid;
      r2_fs      <= r1_fs;
      r2_bg      <= r1_bg;
      r2_spr     <= r1_spr;
      r2_opq     <= r1_opq;
      r2_ball_en <= r1_ball_en;
      r2_d2      <= w_d2;
      r2_s2      <= w_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3
  // ---------------------------------------------------------------------------
  logic               w_ball_on;
  logic [PW-1:0]      w_rgb;
  logic               w_found;
  logic [NUM_SPR-1:0] w_set;
  logic [NUM_SPR-1:0] r_sticky;

  assign w_ball_on = r2_ball_en && (r2_d2 <= {1'b0, r2_s2});

  // Lowest-index opaque sprite wins, then the ball, then the background.
  always_comb begin
    w_rgb   = w_ball_on ? BALL_RGB : r2_bg;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SPR; i++) begin
      if (!w_found && r2_opq[i]) begin
        w_rgb   = r2_spr[PW*i +: PW];
        w_found = 1'b1;
      end
    end
  end

  // Overlap is recorded for every opaque sprite, not only the visible one.
  assign w_set = r2_opq & {NUM_SPR{w_ball_on && r2_valid}};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      r_sticky  <= '0;
      hit       <= '0;
    end else begin
      out_valid <= r2_valid;
      if (r2_valid)
        {Red, Green, Blue} <= w_rgb;
      else
        {Red, Green, Blue} <= '0;
      // The frame_start pixel's own overlap is credited to the frame being closed.
      if (r2_fs) begin
        hit      <= r_sticky | w_set;
        r_sticky <= '0;
      end else begin
        r_sticky <= r_sticky | w_set;
      end
    end
  end

endmodule

// File: doc/color_mapper_pipe.md
COLOR_MAPPER_PIPE -- requirements
Module: color_mapper_pipe

Interface
REQ-001 SHALL have parameter NUM_SPR, default 2, meaning the number of rectangular sprite layers (1..8).
REQ-002 SHALL have parameter CW, default 4, meaning the bits per colour channel.
REQ-003 SHALL have parameter KEY, default {CW{1'b1}},{CW{1'b0}},{CW{1'b1}} (magenta), meaning the transparent sprite colour.
REQ-004 SHALL have parameter BALL_RGB, default 12'hF70 for CW=4, meaning the ball colour.
REQ-005 SHALL have ports Clk, input, 1, system clock; all state on rising edge.
REQ-006 SHALL have port Reset_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have ports DrawX and DrawY, input, 10 each, meaning the current pixel coordinate.
REQ-008 SHALL have port pix_valid, input, 1, meaning the DrawX/DrawY/colour inputs are valid this cycle.
REQ-009 SHALL have port frame_start, input, 1, a one-cycle pulse at the first pixel of a frame.
REQ-010 SHALL have ports SprX, SprY and SprS, input, 10*NUM_SPR each, meaning the packed per-sprite top-left corner and square size.
REQ-011 SHALL have port spr_rgb, input, 3*CW*NUM_SPR, meaning the packed per-sprite texel colour, aligned with DrawX.
REQ-012 SHALL have ports BallX, BallY and Ball_size, input, 10 each, meaning the ball centre and radius.
REQ-013 SHALL have port bg_rgb, input, 3*CW, meaning the background texel, aligned with DrawX.
REQ-014 SHALL have port layer_en, input, NUM_SPR+1, meaning the requested enables; bit NUM_SPR is the ball.
REQ-015 SHALL have ports Red, Green and Blue, output, CW each, meaning the composited pixel.
REQ-016 SHALL have port out_valid, output, 1, meaning Red/Green/Blue are valid.
REQ-017 SHALL have port hit, output, NUM_SPR, meaning the per-sprite ball-overlap flags of the previous frame.

Function
REQ-018 SHALL be a 3-stage pipeline with fixed latency 3: pix_valid at cycle t appears as out_valid at t+3, and the colour at t+3 corresponds to the inputs at t.
REQ-019 Stage 1 SHALL register all pixel-aligned inputs, the signed 11-bit dx=DrawX-BallX and dy=DrawY-BallY, and the per-sprite box hits (DrawX>=SprX && DrawX<SprX+SprS, and likewise for Y).
REQ-020 The box compare SHALL add SprX+SprS at 11 bits, with no wrap at 1023.
REQ-021 Stage 2 SHALL register dx*dx+dy*dy at 21 bits and Ball_size*Ball_size at 20 bits, unsigned.
REQ-022 Stage 3 SHALL register the final colour and out_valid.
REQ-023 A sprite SHALL be opaque at a pixel only when its box hits, its spr_rgb != KEY and its latched enable is 1.
REQ-024 ball_on SHALL be true when dist^2 <= size^2 and the latched ball enable is 1.
REQ-025 Size 0 SHALL make the ball cover only the pixel dx=dy=0.
REQ-026 Colour priority SHALL be: lowest-index opaque sprite, then ball, then bg_rgb; a transparent or disabled sprite falls through.
REQ-027 When out_valid=0, Red/Green/Blue SHALL be 0.
REQ-028 layer_en SHALL be sampled only on a cycle with frame_start=1 into layer_en_q, so enables never change mid-frame.
REQ-029 The frame_start sample SHALL apply starting with that same pixel.
REQ-030 For each sprite i, a sticky flag SHALL set at stage 3 when pix_valid, sprite i is opaque and ball_on all hold, even if a higher sprite wins the colour.
REQ-031 On frame_start, hit SHALL load the sticky flags OR'd with any set event on that same cycle's stage-3 pixel, and the sticky flags SHALL clear.
REQ-032 hit SHALL hold constant for the whole next frame.
REQ-033 frame_start with pix_valid=0 SHALL still latch layer_en and transfer hit.
REQ-034 frame_start SHALL be pipelined alongside the pixel so that the hit transfer occurs at stage 3.

Reset
REQ-035 While Reset_n=0, all pipeline registers, out_valid, Red/Green/Blue, the sticky flags and hit SHALL be 0, and layer_en_q SHALL be all ones.
REQ-036 Reset asserted mid-frame SHALL discard in-flight pixels.
REQ-037 The first out_valid after release SHALL be no earlier than 3 cycles after the first pix_valid.

Verification
REQ-038 Latency: NUM_SPR=2; one pixel (5,5) with pix_valid, bg 0x123, no sprite or ball covering it -> out_valid high exactly 3 cycles later with RGB=1,2,3; otherwise RGB=0.
REQ-039 Priority and transparency: S0 and S1 at (100,100) size 32, spr0=KEY, spr1=0xABC, ball at (110,110) r=8, pixel (110,110) -> 0xABC; with spr1=KEY -> 0xF70.
REQ-040 Circle boundary: ball at (200,200) r=10; pixel (210,200) -> ball colour; (208,207), dist^2 113 > 100 -> background; (0,0) with ball at (0,0) r=0 -> ball colour.
REQ-041 Enable latching: layer_en changed from 3'b111 to 3'b110 mid-frame -> S0 still drawn until the next frame_start, then suppressed from that pixel on.
REQ-042 Collision: S1 opaque under the ball for one pixel in frame N -> hit=2'b10 throughout frame N+1; no overlap in frame N+1 -> hit=0 in frame N+2.
REQ-043 Reset: Reset_n pulsed low for 1 cycle with 2 pixels in flight -> out_valid=0 and hit=0 immediately, and no stale pixel emerges.
